// File: rtl/modulo_contador_sync_decrescente_7_bits.sv
// 7-bit synchronous down counter with terminal-count pulse and optional auto-reload.
// Datapath is a bank of T flip-flops fed by a borrow chain of 2-input ANDs.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | after reset or a load of 0; q holds, en ignored
//   RUN   | counting down one step per enabled edge; busy=1
//   DONE  | q reached 0; waits for load, or reloads when reload=1 and en=1
module modulo_contador_sync_decrescente_7_bits (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       load,
  input  logic       reload,
  input  logic [6:0] d,
  output logic [6:0] q,
  output logic       tc,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [6:0] reload_reg, reload_nxt;
  logic       tc_nxt;
  logic       busy_nxt;
  logic       cnt_en;
  logic       ld_en;
  logic [6:0] ld_val;
  logic [6:0] t_borrow;
  logic [6:0] t_bit;

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      reload_reg <= '0;
      tc         <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      reload_reg <= reload_nxt;
      tc         <= tc_nxt;
      busy       <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    reload_nxt = reload_reg;
    tc_nxt     = 1'b0;
    cnt_en     = 1'b0;
    ld_en      = 1'b0;
    ld_val     = '0;
    if (load) begin
      ld_en      = 1'b1;
      ld_val     = d;
      reload_nxt = d;
      state_nxt  = (d != 7'd0) ? RUN : IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        RUN: begin
          if (en) begin
            cnt_en = 1'b1;
            if (q == 7'd1) begin
              tc_nxt    = 1'b1;
              state_nxt = DONE;
            end
          end
        end
        DONE: begin
          if (reload && en) begin
            ld_en     = 1'b1;
            ld_val    = reload_reg;
            state_nxt = (reload_reg != 7'd0) ? RUN : DONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    busy_nxt = (state_nxt == RUN);
  end

  // Bit i toggles only when every lower bit is 0, i.e. a borrow ripples up to it.
  assign t_borrow[0] = cnt_en;
  genvar i;
  generate
    for (i = 1; i < 7; i++) begin : g_borrow
      assign t_borrow[i] = t_borrow[i-1] & ~q[i-1];
    end
  endgenerate

  // Load/reload forces the toggle pattern that lands q exactly on ld_val.
  assign t_bit = ld_en ? (q ^ ld_val) : t_borrow;

  generate
    for (i = 0; i < 7; i++) begin : g_tff
      always_ff @(posedge clk) begin
        if (clr) q[i] <= 1'b0;
        else     q[i] <= q[i] ^ t_bit[i];
      end
    end
  endgenerate

endmodule
